extender_scheduler: RTL

//  Sequencing controller for the k-mer extender stage. Accepts one batch from the hasher
//  (memory window + INDICES_COUNT k-mer start indices + valid mask), latches it, then emits
//  one extended fragment per handshake on a valid/ready stream to the downstream stage.

---
 rtl/extender_scheduler.sv | 87 ++++++++
 1 files changed

// File: rtl/extender_scheduler.sv
// extender_scheduler: latches one hasher batch and streams one range-checked fragment per handshake
module extender_scheduler #(
  parameter int BASE_LEN      = 4,
  parameter int MEM_LEN       = 128,
  parameter int FRAG_LEN      = 8,
  parameter int INDICES_COUNT = 2,
  parameter int INDICE_LEN    = 5,
  localparam int SLOT_W       = INDICES_COUNT > 1 ? $clog2(INDICES_COUNT) : 1
)(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [MEM_LEN-1:0]                  in_memory,
  input  logic [INDICES_COUNT*INDICE_LEN-1:0] in_indices,
  input  logic [INDICES_COUNT-1:0]            in_mask,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [FRAG_LEN*BASE_LEN-1:0]        out_frag,
  output logic [SLOT_W-1:0]                   out_slot,
  output logic                                out_oob,
  output logic                                out_last,
  output logic                                busy,
  output logic [15:0]                         frag_count
);
  localparam int MEM_BASES = MEM_LEN / BASE_LEN;
  localparam int RW        = INDICE_LEN + 1;
  localparam int FW        = FRAG_LEN * BASE_LEN;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                                 state_q, state_d;
  logic [MEM_LEN-1:0]                     mem_q;
  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] idx_q;
  logic [INDICES_COUNT-1:0]               pend_q;
  logic [15:0]                            frag_count_q;
  logic [SLOT_W-1:0]                      slot;
  logic [INDICE_LEN-1:0]                  start;
  logic                                   oob, last, emit, accept, hs;

  // lowest pending slot wins
  always_comb begin
    slot = '0;
    for (int i = INDICES_COUNT - 1; i >= 0; i--) if (pend_q[i]) slot = SLOT_W'(i);
  end

  // one extra bit so idx+FRAG_LEN cannot wrap before the compare
  assign oob    = ({1'b0, idx_q[slot]} + RW'(FRAG_LEN)) > RW'(MEM_BASES);
  assign start  = oob ? INDICE_LEN'(MEM_BASES - FRAG_LEN) : idx_q[slot];
  assign last   = $onehot(pend_q);
  assign emit   = state_q == EMIT;
  assign accept = !emit && in_valid;
  assign hs     = emit && out_ready;

  always_comb begin
    state_d = accept ? ((|in_mask) ? EMIT : IDLE) : (hs && last) ? IDLE : state_q;
  end

  assign in_ready   = !emit;
  assign out_valid  = emit;
  assign busy       = emit;
  assign out_frag   = emit ? FW'(mem_q >> (start * BASE_LEN)) : '0;
  assign out_slot   = emit ? slot : '0;
  assign out_oob    = emit && oob;
  assign out_last   = emit && last;
  assign frag_count = frag_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      frag_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mem_q  <= in_memory;
        idx_q  <= in_indices;
        pend_q <= in_mask;
      end else if (hs) begin
        pend_q       <= pend_q & ~(INDICES_COUNT'(1) << slot);
        frag_count_q <= frag_count_q + 16'd1;
      end
    end
  end
endmodule
